// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared constants for the EX stage. Covers instruction-type
//               codes, the RV32M func3/func7 encodings, and the state
//               encoding of the iterative multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    // Instruction-type constants shared with the single-cycle ALU path
    localparam logic [6:0] OPCODE_OP  = 7'b0110011;
    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_SUB  = 7'b0100000;
    localparam logic [6:0] FUNC7_M    = 7'b0000001;

    // M-extension func3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIN  = 2'd3
    } md_state_e;

    // Divide-family ops all have func3[2] set
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // REM/REMU return the remainder rather than the quotient
    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic f3_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic f3_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage : muldiv_sequencer_pkg
`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Request/response bundle between the decode/EX pipeline
//               (master) and the multi-cycle multiply/divide unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface : muldiv_sequencer_if
`default_nettype wire

// File: rtl/muldiv_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of the shared shift-add / restoring-subtract
//               datapath. Purely combinational.
//               Multiply: {acc, shreg} is the 2*XLEN product register and
//                         shreg[0] is the current multiplier bit.
//               Divide  : acc is the partial remainder, shreg the dividend
//                         shifting out / quotient shifting in.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  wire logic            mode_i,     // 0 = multiply, 1 = divide
    input  wire logic [XLEN-1:0] acc_i,
    input  wire logic [XLEN-1:0] shreg_i,
    input  wire logic [XLEN-1:0] operand_i,  // multiplicand or divisor
    output logic      [XLEN-1:0] acc_o,
    output logic      [XLEN-1:0] shreg_o
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    // Single iteration: add-then-shift-right, or shift-left-then-compare
    always_comb begin
        // Carry out of the add lands in the top bit and shifts back down
        w_sum    = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : '0);
        // Remainder gains one bit of headroom before the compare
        w_rem_sh = {acc_i, shreg_i[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, operand_i};
        w_ge     = (w_rem_sh >= {1'b0, operand_i});

        if (mode_i) begin
            acc_o   = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            shreg_o = {shreg_i[XLEN-2:0], w_ge};
        end else begin
            acc_o   = w_sum[XLEN:1];
            shreg_o = {w_sum[0], shreg_i[XLEN-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle RV32M execution unit. Owns the FSM, iteration
//               counter, operand sign handling and result register. The
//               per-bit arithmetic lives in muldiv_step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    muldiv_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e         state_q;
    logic [2:0]        func3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   shreg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              fast_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Operand preparation (used in PREP)
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_val;
    logic              w_neg_res;

    // Result formation (used in FIN)
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quot_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_fin_val;

    // Iteration datapath outputs
    logic [XLEN-1:0]   w_step_acc;
    logic [XLEN-1:0]   w_step_shreg;

    // Magnitudes, result sign and fast-path detection from latched operands
    always_comb begin
        w_is_div  = f3_is_div(func3_q);
        w_is_rem  = f3_is_rem(func3_q);
        w_neg_a   = f3_signed_a(func3_q) & a_q[XLEN-1];
        w_neg_b   = f3_signed_b(func3_q) & b_q[XLEN-1];
        w_mag_a   = w_neg_a ? (~a_q + 1'b1) : a_q;
        w_mag_b   = w_neg_b ? (~b_q + 1'b1) : b_q;
        w_div0    = w_is_div && (b_q == '0);
        w_ovf     = ((func3_q == F3_DIV) || (func3_q == F3_REM)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
        w_fast    = w_div0 || w_ovf;
        if (w_div0) begin
            w_fast_val = w_is_rem ? a_q : '1;
        end else begin
            w_fast_val = w_is_rem ? '0 : a_q;
        end
        // Remainder follows the dividend; everything else is the XOR
        w_neg_res = w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
    end

    // Sign correction and result selection once the iterations are done
    always_comb begin
        w_prod   = {acc_q, shreg_q};
        w_prod_s = neg_q ? (~w_prod + 1'b1) : w_prod;
        w_quot_s = neg_q ? (~shreg_q + 1'b1) : shreg_q;
        w_rem_s  = neg_q ? (~acc_q + 1'b1) : acc_q;
        if (fast_q) begin
            w_fin_val = acc_q;
        end else if (w_is_div) begin
            w_fin_val = w_is_rem ? w_rem_s : w_quot_s;
        end else if (func3_q == F3_MUL) begin
            w_fin_val = w_prod_s[XLEN-1:0];
        end else begin
            w_fin_val = w_prod_s[2*XLEN-1:XLEN];
        end
    end

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_i    (w_is_div),
        .acc_i     (acc_q),
        .shreg_i   (shreg_q),
        .operand_i (opnd_q),
        .acc_o     (w_step_acc),
        .shreg_o   (w_step_shreg)
    );

    // Sequencer FSM with registered done/result; flush beats everything but reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            func3_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start && !bus.flush) begin
                            func3_q <= bus.func3;
                            a_q     <= bus.op_a;
                            b_q     <= bus.op_b;
                            state_q <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        cnt_q   <= '0;
                        neg_q   <= w_neg_res;
                        fast_q  <= w_fast;
                        // Fast-path value parks in acc so FIN can pick it up
                        acc_q   <= w_fast ? w_fast_val : '0;
                        shreg_q <= w_is_div ? w_mag_a : w_mag_b;
                        opnd_q  <= w_is_div ? w_mag_b : w_mag_a;
                        state_q <= w_fast ? ST_FIN : ST_CALC;
                    end
                    ST_CALC: begin
                        acc_q   <= w_step_acc;
                        shreg_q <= w_step_shreg;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            state_q <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        result_q <= w_fin_val;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. Table of directed
//               vectors with hand-computed results and latencies, plus
//               hand-written flush, held-start, reset and IDLE-flush cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(
        .XLEN (XLEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency/result/busy/pulse width
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int cyc;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_latency"}, 32'(cyc), 32'(lat));
        check({nm, "_result"}, bus.result, exp);
        check({nm, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({nm, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({nm, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int   cyc;
        int   ndone;
        logic [31:0] old_res;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.func3 = 3'b000;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;

        // Hand-computed vectors: {func3, op_a, op_b, result, cycles E0->done}
        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34}); // MUL 7*-3
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34}); // MULH
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34}); // MULHU
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34}); // MULHSU -1*2
        vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        34}); // DIVU
        vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         34}); // REMU
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34}); // DIV -7/2
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34}); // REM -7%2
        vecs.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2});  // DIV /0
        vecs.push_back('{3'b110, 32'd5,         32'd0,         32'd5,         2});  // REM /0
        vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2});  // DIVU /0
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});  // DIV ovf
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2});  // REM ovf
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34}); // DIVU no ovf
        vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34}); // REMU
        vecs.push_back('{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34}); // MUL low
        vecs.push_back('{3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 34}); // MULH high
        vecs.push_back('{3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0002, 34}); // DIV -8/-3
        vecs.push_back('{3'b110, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34}); // REM -8%-3

        // Reset state while held in reset and just after release
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // Table-driven vectors, issued back-to-back
        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // flush and start together in IDLE: nothing accepted
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.func3 = 3'b000;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle_flush_busy", 32'(bus.busy), 32'd0);

        // Flush a MUL at cycle 10: back to IDLE, no done, result retained
        old_res = bus.result;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'b000;
        bus.op_a  = 32'd5;
        bus.op_b  = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_idle_next", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("flush_no_done", 32'(ndone), 32'd0);
        check("flush_result_kept", bus.result, old_res);
        run_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "post_flush_divu");

        // Start held through the whole op: one completion only, latency unchanged
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'b100;
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd7;
        @(posedge clk);
        #1;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("held_start_latency", 32'(cyc), 32'd34);
        check("held_start_result", bus.result, 32'd14);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("held_start_no_second_done", 32'(ndone), 32'd0);
        check("held_start_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset at cycle 15 of a DIV
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'b100;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("mid_rst_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        run_op(3'b000, 32'd6, 32'd7, 32'd42, 34, "post_rst_mul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_muldiv_sequencer
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M execution unit for the core's EX stage. It sequences one shared iterative shift-add/restore-subtract datapath for all eight M-extension ops, one bit per cycle.
- Driven by the decode stage (start, func3, operands); signals the pipeline to stall while busy.
- Sits beside the single-cycle ALU; the EX result mux selects it for R-type with func7 = 0000001.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- func3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (multiplicand/dividend), sampled with start
- op_b  in  XLEN  rs2 value (multiplier/divisor), sampled with start
- flush  in  1  pipeline kill; aborts the current op
- busy  out  1  high in every state except IDLE; drives the pipeline stall
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result; held until the next accepted start

Behaviour:
- Reset (rst_n low, async): state IDLE; busy, done and counter 0; result 0; operand registers 0.
- FSM states: IDLE, PREP, CALC, FIN.
- IDLE:
  - start=1 at edge E0 latches func3, op_a, op_b and moves to PREP.
  - start while not IDLE is ignored, with no queuing.
- PREP (1 cycle):
  - Take magnitudes of signed operands; record result sign; clear accumulator; counter = 0.
  - Signed: MUL/MULH both operands; MULHSU op_a only; DIV/REM both.
  - Fast paths go PREP to FIN and skip CALC:
    - divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a.
    - signed overflow (DIV/REM with op_a = 1 followed by XLEN-1 zeros and op_b = all-ones): DIV gives op_a, REM gives 0.
  - Otherwise go to CALC.
- CALC (exactly XLEN cycles):
  - Multiply: 2*XLEN-bit product; each cycle, if multiplier LSB is set, add multiplicand to the upper half, then shift right by 1.
  - Divide: restoring. Shift {rem, quot} left 1; if rem >= divisor, subtract and set quotient LSB.
  - Counter increments each cycle; at count = XLEN-1 go to FIN.
- FIN (1 cycle):
  - Apply sign correction with two's-complement negate.
  - MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN].
  - Remainder takes the sign of the dividend.
  - Register result; done=1; go to IDLE.
- Latency: done high in the cycle after edge E0+XLEN+2 (34 cycles for XLEN=32). Fast path: after edge E0+2.
- done is never high for two consecutive cycles. busy falls in the same cycle done rises (FIN counts as busy; IDLE follows).
- Back-to-back: start may be asserted in the cycle after FIN. Start during FIN is ignored.
- flush in any non-IDLE state: next edge goes to IDLE; no done; result keeps its old value. flush in IDLE has no effect. flush and start together in IDLE: flush wins, nothing accepted.
- rst_n low mid-operation: immediate return to reset values.
- All arithmetic is unsigned on internal magnitudes, with XLEN+1-bit subtract for the compare; negation wraps modulo 2^XLEN.

Decomposition:
- Shared constants header (alongside existing ALU/instruction-type constants): M-extension func3 codes, the func7 M value 0000001, FSM state encodings.
- One sub-module, muldiv_step: purely combinational single-iteration step (mode, acc, shreg, operand in; next acc, shreg out).
- FSM, counter, sign handling and result register stay in muldiv_sequencer.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD: busy for 34 cycles, done at cycle 34, result 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 gives 0xFFFFFFFF.
- DIVU 100/7 gives 14; REMU gives 2. DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF.
- DIV x/0 with x=5 gives 0xFFFFFFFF, done at cycle 2; REM 5/0 gives 5. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 at cycle 2; REM gives 0.
- Start MUL, flush at cycle 10: IDLE next cycle, done never pulses, result unchanged. A new DIVU 9/3 then completes with result 3.
- rst_n low at cycle 15 of a DIV: busy and done 0 immediately, result 0. Start held high during busy is ignored, with no second done.
